// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : argmax_pkg
// Brief    : Shared compare rule, beat derivation and parameter checks for argmax.
// Revision : 1.0
// ============================================================================
package argmax_pkg;

  localparam int unsigned C_CMP_WIDTH = 64;

  typedef logic [C_CMP_WIDTH-1:0] cmp_word_t;

  function automatic int unsigned beats_of(input int unsigned vector_length,
                                           input int unsigned lanes);
    return (lanes == 0) ? 1 : vector_length / lanes;
  endfunction

  function automatic bit params_legal(input int unsigned vector_length,
                                      input int unsigned lanes,
                                      input int unsigned data_width);
    return (lanes >= 1) && (vector_length >= 2) && (vector_length % lanes == 0) &&
           (data_width >= 1) && (data_width <= C_CMP_WIDTH);
  endfunction

  // Operands arrive already sign- or zero-extended to the compare width.
  // The candidate always carries the higher index, so tie_last favours it.
  function automatic logic better(input cmp_word_t cand,
                                  input cmp_word_t inc,
                                  input logic      signed_mode,
                                  input logic      tie_last);
    logic gt;
    if (signed_mode) gt = $signed(cand) > $signed(inc);
    else             gt = cand > inc;
    return gt || (tie_last && (cand == inc));
  endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_lane_reduce.sv
`default_nettype none
// ============================================================================
// Module   : argmax_lane_reduce
// Brief    : Combinational LANES-wide compare yielding winning lane and value.
// Revision : 1.0
// ============================================================================
module argmax_lane_reduce
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 2,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          TIE_LAST   = 1'b1,
  parameter int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  output logic [LANE_W-1:0]           o_best_lane,
  output logic [DATA_WIDTH-1:0]       o_best_value
);

  function automatic cmp_word_t widen(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED) return cmp_word_t'($signed(v));
    else        return cmp_word_t'(v);
  endfunction

  logic [DATA_WIDTH-1:0] w_cand;

  // Lanes are folded in ascending order so the incumbent always has the lower index.
  always_comb begin
    o_best_lane  = '0;
    o_best_value = i_data[DATA_WIDTH-1:0];
    w_cand       = '0;
    for (int l = 1; l < LANES; l++) begin
      w_cand = i_data[l*DATA_WIDTH +: DATA_WIDTH];
      if (better(widen(w_cand), widen(o_best_value), SIGNED, TIE_LAST)) begin
        o_best_lane  = LANE_W'(l);
        o_best_value = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream
// Brief    : Streaming multi-lane arg-max reducer with registered, back-pressured result.
// Revision : 1.0
// ============================================================================
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned VECTOR_LENGTH = 10,
  parameter int unsigned LANES         = 2,
  parameter bit          SIGNED        = 1'b0,
  parameter bit          TIE_LAST      = 1'b1,
  parameter int unsigned INDEX_WIDTH   = $clog2(VECTOR_LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INDEX_WIDTH-1:0]      out_index,
  output logic [DATA_WIDTH-1:0]       out_value
);

  localparam int unsigned           C_BEATS     = beats_of(VECTOR_LENGTH, LANES);
  localparam int unsigned           C_BEAT_W    = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam int unsigned           C_LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [C_BEAT_W-1:0]   C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);

  if (!params_legal(VECTOR_LENGTH, LANES, DATA_WIDTH)) begin : g_param_check
    $error("argmax_stream: VECTOR_LENGTH must be >= 2 and a multiple of LANES");
  end

  function automatic cmp_word_t widen(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED) return cmp_word_t'($signed(v));
    else        return cmp_word_t'(v);
  endfunction

  logic [C_BEAT_W-1:0]    beat_cnt_q,   beat_cnt_d;
  logic [DATA_WIDTH-1:0]  best_value_q, best_value_d;
  logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
  logic                   out_valid_q,  out_valid_d;
  logic [INDEX_WIDTH-1:0] out_index_q,  out_index_d;
  logic [DATA_WIDTH-1:0]  out_value_q,  out_value_d;
  logic                   rst_n_synced_q;

  logic [C_LANE_W-1:0]    w_lane;
  logic [DATA_WIDTH-1:0]  w_beat_value;
  logic [INDEX_WIDTH-1:0] w_beat_index;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_last;
  logic                   w_take_beat;
  logic [DATA_WIDTH-1:0]  w_merged_value;
  logic [INDEX_WIDTH-1:0] w_merged_index;

  argmax_lane_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SIGNED     (SIGNED),
    .TIE_LAST   (TIE_LAST),
    .LANE_W     (C_LANE_W)
  ) u_lane_reduce (
    .i_data       (in_data),
    .o_best_lane  (w_lane),
    .o_best_value (w_beat_value)
  );

  // Holds off acceptance for the first edge after reset release.
  assign in_ready = rst_n_synced_q && !flush && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_first  = (beat_cnt_q == '0);
  assign w_last   = (beat_cnt_q == C_LAST_BEAT);

  assign w_beat_index = INDEX_WIDTH'(beat_cnt_q) * INDEX_WIDTH'(LANES) + INDEX_WIDTH'(w_lane);

  // Beat indices always exceed the running best's, so the beat is the candidate.
  assign w_take_beat    = w_first ||
                          better(widen(w_beat_value), widen(best_value_q), SIGNED, TIE_LAST);
  assign w_merged_value = w_take_beat ? w_beat_value : best_value_q;
  assign w_merged_index = w_take_beat ? w_beat_index : best_index_q;

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_value_d  = out_value_q;

    if (out_ready) out_valid_d = 1'b0;

    if (flush) begin
      beat_cnt_d = '0;
    end else if (w_accept) begin
      if (w_last) begin
        out_valid_d = 1'b1;
        out_index_d = w_merged_index;
        out_value_d = w_merged_value;
        beat_cnt_d  = '0;
      end else begin
        best_value_d = w_merged_value;
        best_index_d = w_merged_index;
        beat_cnt_d   = beat_cnt_q + C_BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q     <= '0;
      best_value_q   <= '0;
      best_index_q   <= '0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      out_value_q    <= '0;
      rst_n_synced_q <= 1'b0;
    end else begin
      beat_cnt_q     <= beat_cnt_d;
      best_value_q   <= best_value_d;
      best_index_q   <= best_index_d;
      out_valid_q    <= out_valid_d;
      out_index_q    <= out_index_d;
      out_value_q    <= out_value_d;
      rst_n_synced_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_value = out_value_q;

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_stream
// Brief    : Scoreboard bench for argmax_stream: unsigned/tie-last and signed-8/tie-first DUTs.
// Revision : 1.0
// ============================================================================
module tb_argmax_stream;

  localparam int unsigned DW    = 32;
  localparam int unsigned DW1   = 8;
  localparam int unsigned VL    = 10;
  localparam int unsigned LN    = 2;
  localparam int unsigned BEATS = VL / LN;
  localparam int unsigned IW    = $clog2(VL);

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              flush     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b1;
  logic [LN*DW-1:0]  in_data   = '0;
  logic [LN*DW1-1:0] in_data1;

  logic              in_ready0, out_valid0, in_ready1, out_valid1;
  logic [IW-1:0]     out_index0, out_index1;
  logic [DW-1:0]     out_value0;
  logic [DW1-1:0]    out_value1;

  for (genvar l = 0; l < LN; l++) begin : g_lane8
    assign in_data1[l*DW1 +: DW1] = in_data[l*DW +: DW1];
  end

  argmax_stream #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .LANES(LN), .SIGNED(1'b0), .TIE_LAST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_index(out_index0), .out_value(out_value0));

  argmax_stream #(.DATA_WIDTH(DW1), .VECTOR_LENGTH(VL), .LANES(LN), .SIGNED(1'b1), .TIE_LAST(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_index(out_index1), .out_value(out_value1));

  always #5 clk = ~clk;

  logic [1:0]       mon_valid;
  logic [1:0][63:0] mon_word;
  assign mon_valid[0] = out_valid0;
  assign mon_valid[1] = out_valid1;
  assign mon_word[0]  = {32'(out_index0), 32'(out_value0)};
  assign mon_word[1]  = {32'(out_index1), 32'(out_value1)};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-vector arg-max straight from the scoring rules.
  logic [63:0]   exp_q0[$];
  logic [63:0]   exp_q1[$];
  logic [DW-1:0] mvec [VL];
  logic [DW-1:0] stim [VL];
  int            mbeat = 0;
  bit            rand_rdy = 1'b0;

  task automatic model_vector();
    int b0 = 0;
    int b1 = 0;
    for (int i = 1; i < int'(VL); i++) begin
      if (mvec[i] >= mvec[b0]) b0 = i;
      if ($signed(mvec[i][7:0]) > $signed(mvec[b1][7:0])) b1 = i;
    end
    exp_q0.push_back({32'(b0), mvec[b0]});
    exp_q1.push_back({32'(b1), 32'(mvec[b1][7:0])});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [LN*DW-1:0] d);
    bit acc = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk); #1;
      if (acc) break;
      waited++;
      if (waited > 300) begin
        check("beat_accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid = 1'b0;
    if (acc) begin
      for (int l = 0; l < int'(LN); l++) mvec[mbeat*int'(LN) + l] = d[l*DW +: DW];
      if (mbeat == int'(BEATS) - 1) begin
        model_vector();
        mbeat = 0;
      end else begin
        mbeat++;
      end
    end
  endtask

  task automatic send_vec(input int gap_max);
    logic [LN*DW-1:0] d;
    for (int b = 0; b < int'(BEATS); b++) begin
      idle(int'($urandom_range(0, 32'(gap_max))));
      for (int l = 0; l < int'(LN); l++) d[l*DW +: DW] = stim[b*int'(LN) + l];
      send_beat(d);
    end
  endtask

  function automatic logic [DW-1:0] rand_score();
    case ($urandom_range(0, 2))
      0:       return DW'($urandom_range(0, 7));
      1:       return DW'($urandom);
      default: return 32'hFFFF_FFF8 | DW'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic rand_stim();
    for (int i = 0; i < int'(VL); i++) stim[i] = rand_score();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", 64'(in_ready0), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    mbeat = 0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops an expectation per consumed result and checks hold stability.
  bit          stall_prev [2];
  logic [63:0] stall_word [2];
  initial begin
    stall_prev[0] = 1'b0;
    stall_prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      check("in_ready_lockstep", 64'(in_ready1), 64'(in_ready0));
      for (int d = 0; d < 2; d++) begin
        logic [63:0] e;
        if (stall_prev[d] && rst_n) begin
          check($sformatf("hold_valid_dut%0d", d), 64'(mon_valid[d]), 64'(1));
          check($sformatf("hold_stable_dut%0d", d), mon_word[d], stall_word[d]);
        end
        if (mon_valid[d] && out_ready) begin
          if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check($sformatf("unexpected_result_dut%0d", d), 64'(1), 64'(0));
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("result_dut%0d", d), mon_word[d], e);
          end
        end
        stall_prev[d] = mon_valid[d] && !out_ready && rst_n;
        stall_word[d] = mon_word[d];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid0), 64'(0));
    check("reset_out_index", 64'(out_index0), 64'(0));
    check("reset_out_value", 64'(out_value0), 64'(0));
    check("reset_in_ready",  64'(in_ready0),  64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector with a tie at indices 1 and 4.
    stim = '{32'd3, 32'd9, 32'd1, 32'd4, 32'd9, 32'd0, 32'd2, 32'd2, 32'd8, 32'd5};
    send_vec(0);
    check("t1_latency_valid", 64'(out_valid0), 64'(1));
    check("t1_index_tie_last",  64'(out_index0), 64'(4));
    check("t1_value",           64'(out_value0), 64'(9));
    check("t1_index_tie_first", 64'(out_index1), 64'(1));
    check("t1_value_s8",        64'(out_value1), 64'(9));

    // Negative scores: unsigned view picks 0xFFFFFFFE last, signed-8 picks -2 first.
    stim = '{32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFF7,
             32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7};
    send_vec(1);
    check("t2_index_unsigned", 64'(out_index0), 64'(3));
    check("t2_value_unsigned", 64'(out_value0), 64'(32'hFFFF_FFFE));
    check("t2_index_signed",   64'(out_index1), 64'(1));
    check("t2_value_signed",   64'(out_value1), 64'(8'hFE));

    // Back-pressure: first result held while a second vector waits.
    idle(2);
    out_ready = 1'b0;
    rand_stim();
    send_vec(0);
    check("bp_first_valid", 64'(out_valid0), 64'(1));
    rand_stim();
    fork
      send_vec(0);
    join_none
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready0), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    idle(3);

    // Flush: two large partial beats must not influence the next vector.
    send_beat({LN{32'hFFFF_FFFF}});
    send_beat({LN{32'hFFFF_FFFF}});
    do_flush();
    for (int i = 1; i < int'(VL); i++) stim[i] = $urandom & 32'h7FFF_FF7E;
    stim[0] = 32'hFFFF_FF7F;
    send_vec(0);
    check("flush_index_u", 64'(out_index0), 64'(0));
    check("flush_index_s", 64'(out_index1), 64'(0));
    check("flush_value_u", 64'(out_value0), 64'(32'hFFFF_FF7F));

    // Asynchronous reset mid-vector after a non-zero result.
    stim = '{32'd3, 32'd9, 32'd1, 32'd4, 32'd9, 32'd0, 32'd2, 32'd2, 32'd8, 32'd5};
    send_vec(0);
    idle(2);
    send_beat({LN{rand_score()}});
    send_beat({LN{rand_score()}});
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid0), 64'(0));
    check("arst_out_index", 64'(out_index0), 64'(0));
    check("arst_out_value", 64'(out_value0), 64'(0));
    check("arst_out_index_s", 64'(out_index1), 64'(0));
    mbeat = 0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd70, 32'd8, 32'd9, 32'd10};
    send_vec(0);
    check("post_rst_index", 64'(out_index0), 64'(6));
    check("post_rst_value", 64'(out_value0), 64'(70));

    // Randomised traffic with random back-pressure and occasional flushes.
    rand_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      rand_stim();
      if (v % 7 == 3) begin
        rand_stim();
        repeat ($urandom_range(1, BEATS - 1)) send_beat({rand_score(), rand_score()});
        do_flush();
      end
      send_vec(3);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(6);
    check("drain_dut0", 64'(exp_q0.size()), 64'(0));
    check("drain_dut1", 64'(exp_q1.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
